// File: rtl/sevseg_pkg.sv
// Shared types and constants for the 7-segment frame scanner.
// Segment encodings are active-low, bit0 = a ... bit6 = g.
package sevseg_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry k is the glyph for hex digit k; the list is written F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/sevseg_frame_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg
    import sevseg_pkg::*;
(
    input  nibble_t    nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/sevseg_frame_scanner.sv
// Frame-buffered, tear-free multiplexer for a common-anode 7-segment display.
// Define SEVSEG_LZB_EN to blank leading-zero digits (digit 0 always shown).
module sevseg_frame_scanner
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int WORD_NIBBLES = 7,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*WORD_NIBBLES-1:0] frame_in,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    output logic                      frame_done,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int PW   = $clog2(PRESCALE);
    localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BASE = WORD_NIBBLES - NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_LEN  = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    scan_state_t               state_q, state_d;
    logic [4*WORD_NIBBLES-1:0] shadow_q, shadow_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic [DW-1:0]             digit_q, digit_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      done_q, done_d;

    logic       tick;
    logic       boundary;
    logic       accept;
    nibble_t    cur_nib;
    logic       lead_blank;
    logic [6:0] dec_seg;

    assign tick     = (state_q == SCAN) && (presc_q == PRESC_LAST);
    assign boundary = tick && (digit_q == DIGIT_LAST);
    // A new frame may only land while idle or on the last cycle of the last digit.
    assign frame_ready = (state_q == IDLE) || boundary;
    assign accept      = frame_valid && frame_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        presc_d  = presc_q;
        digit_d  = digit_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_d = frame_in;
                    presc_d  = '0;
                    digit_d  = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
                end
                if (accept) begin
                    shadow_d = frame_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_nib = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_q == DW'(d)) begin
                cur_nib = shadow_q[4*(BASE+d) +: 4];
            end
        end
    end

`ifdef SEVSEG_LZB_EN
    always_comb begin : lzb
        logic zero_run;
        zero_run   = 1'b1;
        lead_blank = 1'b0;
        // Walk from the most significant digit down; the zero run breaks at the first non-zero.
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (shadow_q[4*(BASE+d) +: 4] == 4'h0);
            if (digit_q == DW'(d)) begin
                lead_blank = zero_run && (d != 0);
            end
        end
    end
`else
    assign lead_blank = 1'b0;
`endif

    hex_to_seg u_hex_to_seg (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        seg_d  = SEG_OFF;
        an_d   = '1;
        done_d = boundary;
        if ((state_q == SCAN) && (presc_q >= BLANK_LEN)) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                an_d[d] = (digit_q != DW'(d));
            end
            seg_d = lead_blank ? SEG_OFF : dec_seg;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            presc_q  <= '0;
            digit_q  <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= '1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            done_q   <= done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_sevseg_frame_scanner.sv
// Directed bench for sevseg_frame_scanner with PRESCALE=4, BLANK_CYCLES=1.
// Leading-zero expectations follow SEVSEG_LZB_EN when defined.
module tb_sevseg_frame_scanner;

    logic        clk;
    logic        rst;
    logic [27:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    sevseg_frame_scanner #(
        .NUM_DIGITS   (4),
        .WORD_NIBBLES (7),
        .PRESCALE     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .seg         (seg),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full 16-cycle scan: per slot, one blank cycle then three driven cycles.
    task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] segs [4];
        logic [3:0] an_exp;
        int slot;
        int pos;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            slot   = (i - 1) / 4;
            pos    = (i - 1) % 4;
            an_exp = 4'hF;
            if (pos == 0) begin
                check($sformatf("%s_c%0d_an", tag, i), 32'(an), 32'(an_exp));
                check($sformatf("%s_c%0d_seg", tag, i), 32'(seg), 32'h7F);
            end else begin
                an_exp[slot] = 1'b0;
                check($sformatf("%s_c%0d_an", tag, i), 32'(an), 32'(an_exp));
                check($sformatf("%s_c%0d_seg", tag, i), 32'(seg), 32'(segs[slot]));
            end
            check($sformatf("%s_c%0d_ready", tag, i), 32'(frame_ready), (i == 15) ? 32'd1 : 32'd0);
            check($sformatf("%s_c%0d_done", tag, i), 32'(frame_done), (i == 16) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [6:0] lz_hi;
`ifdef SEVSEG_LZB_EN
        lz_hi = 7'h7F;
`else
        lz_hi = 7'h40;
`endif
        rst         = 1'b0;
        frame_valid = 1'b0;
        frame_in    = '0;

        repeat (2) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_ready", 32'(frame_ready), 32'd1);
        check("rst_done", 32'(frame_done), 32'd0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_an", 32'(an), 32'hF);
        check("idle_seg", 32'(seg), 32'h7F);
        check("idle_ready", 32'(frame_ready), 32'd1);
        check("idle_done", 32'(frame_done), 32'd0);

        frame_in    = 28'h1234567;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        check("load_ready_low", 32'(frame_ready), 32'd0);
        run_frame("f1", 7'h19, 7'h30, 7'h24, 7'h79);

        // New frame offered for a whole scan; it may only land at the boundary.
        frame_in    = 28'h8F00000;
        frame_valid = 1'b1;
        run_frame("f2", 7'h19, 7'h30, 7'h24, 7'h79);
        frame_valid = 1'b0;
        run_frame("f3", 7'h40, 7'h40, 7'h0E, 7'h00);

        repeat (10) @(negedge clk);
        check("mid_an", 32'(an), 32'hB);
        check("mid_seg", 32'(seg), 32'h0E);

        rst = 1'b0;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_ready", 32'(frame_ready), 32'd1);
        check("midrst_done", 32'(frame_done), 32'd0);

        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_c%0d_an", i), 32'(an), 32'hF);
            check($sformatf("post_rst_c%0d_ready", i), 32'(frame_ready), 32'd1);
        end

        frame_in    = 28'h0070000;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        run_frame("lz1", 7'h40, 7'h78, lz_hi, lz_hi);
        run_frame("lz2", 7'h40, 7'h78, lz_hi, lz_hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
